iter_divider: RTL

- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits in the EX stage beside the multiplier and consumes the forwarded EX operands.
- Uses the same start/busy handshake as the multiplier, so the pipeline holds ID/EX and EX/MEM while busy=1.
- The result is registered and is captured by EX/MEM on the first cycle busy is low.

---
 rtl/iter_divider.sv | 136 +++++++++++++
 1 files changed

// File: rtl/iter_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle, sign fix-up in a final cycle.
module iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        SPECIAL
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] babs_q;
    logic [CW-1:0]    cnt_q;
    logic             op_rem_q;
    logic             sign_q_q;
    logic             sign_r_q;
    logic [WIDTH-1:0] result_q;
    logic             busy_q;
    logic             done_q;

    logic             accept;
    logic             op_signed;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             div0;
    logic             ovf;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] trial;
    logic             trial_neg;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign accept    = start & ~busy_q & funct3[2];
    assign op_signed = ~funct3[0];
    assign a_abs     = (op_signed & a[WIDTH-1]) ? -a : a;
    assign b_abs     = (op_signed & b[WIDTH-1]) ? -b : b;
    assign div0      = (b == '0);
    assign ovf       = op_signed & (a == MIN_NEG) & (b == '1);

    // Extra top bit keeps the shifted remainder exact for large unsigned divisors
    assign rem_sh    = {rem_q, quo_q[WIDTH-1]};
    assign trial     = {1'b0, rem_sh} - {2'b00, babs_q};
    assign trial_neg = trial[WIDTH+1];

    assign q_fix     = sign_q_q ? -quo_q : quo_q;
    assign r_fix     = sign_r_q ? -rem_q : rem_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            quo_q    <= '0;
            babs_q   <= '0;
            cnt_q    <= '0;
            op_rem_q <= 1'b0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_rem_q <= funct3[1];
                        sign_q_q <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        sign_r_q <= op_signed & a[WIDTH-1];
                        babs_q   <= b_abs;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        if (div0 | ovf) begin
                            // Special results are staged in rem/quo directly
                            state_q <= SPECIAL;
                            rem_q   <= div0 ? a : '0;
                            quo_q   <= div0 ? '1 : MIN_NEG;
                        end else begin
                            state_q <= CALC;
                            rem_q   <= '0;
                            quo_q   <= a_abs;
                        end
                    end
                end
                CALC: begin
                    quo_q <= {quo_q[WIDTH-2:0], ~trial_neg};
                    rem_q <= trial_neg ? rem_sh[WIDTH-1:0]
                                       : trial[WIDTH-1:0];
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    result_q <= op_rem_q ? r_fix : q_fix;
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                end
                SPECIAL: begin
                    result_q <= op_rem_q ? rem_q : quo_q;
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
